// File: rtl/cavlc_bit_accumulator.sv
// Packs left-aligned, MSB-first variable-length code chunks into a continuous
// bitstream and emits 32-bit big-endian words, with a zero-padded flush at block end.
module cavlc_bit_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_code,
    input  logic [6:0]  in_len,
    input  logic        flush_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [5:0]  out_nbits,
    output logic        flush_done,
    output logic [23:0] total_bits
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [95:0] buf_reg, buf_next;
    logic [6:0]  fill_reg, fill_next;
    logic [23:0] total_reg, total_next;

    logic [6:0]  len_c;
    logic [63:0] code_mask;
    logic [63:0] code_masked;
    logic [95:0] chunk_placed;
    logic [6:0]  pop_amt;
    logic [6:0]  append_off;
    logic        accept;
    logic        pop;
    logic [31:0] tail_mask;

    assign len_c = (in_len > 7'd64) ? 7'd64 : in_len;

    // Keep bit gi only if it lies inside the top len_c bits of the chunk.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_code_mask
            assign code_mask[gi] = ({1'b0, 7'(gi)} + {1'b0, len_c}) >= 8'd64;
        end
    endgenerate

    assign code_masked = in_code & code_mask;

    // Outputs come only from registered state.
    always_comb begin
        in_ready   = (state_reg == S_RUN) && (fill_reg <= 7'd32);
        out_last   = (state_reg == S_FLUSH) && (fill_reg != 7'd0) && (fill_reg <= 7'd32);
        out_valid  = ((state_reg == S_RUN) && (fill_reg >= 7'd32)) ||
                     ((state_reg == S_FLUSH) && (fill_reg != 7'd0));
        tail_mask  = ~(32'hFFFF_FFFF >> fill_reg[5:0]);
        out_data   = 32'd0;
        out_nbits  = 6'd0;
        if (out_valid) begin
            out_data  = out_last ? (buf_reg[95:64] & tail_mask) : buf_reg[95:64];
            out_nbits = out_last ? fill_reg[5:0] : 6'd32;
        end
        flush_done = (state_reg == S_DONE);
        total_bits = total_reg;
    end

    always_comb begin
        accept       = in_valid && in_ready;
        pop          = out_valid && out_ready;
        pop_amt      = pop ? (out_last ? fill_reg : 7'd32) : 7'd0;
        append_off   = fill_reg - pop_amt;
        chunk_placed = {code_masked, 32'd0} >> append_off;

        state_next = state_reg;
        buf_next   = buf_reg;
        fill_next  = fill_reg;
        total_next = total_reg;

        // Appends land below fill, so the word on out_data is never disturbed.
        if (pop) begin
            buf_next = out_last ? 96'd0 : (buf_reg << 32);
        end
        if (accept) begin
            buf_next   = buf_next | chunk_placed;
            total_next = total_reg + {17'd0, len_c};
        end
        fill_next = fill_reg - pop_amt + (accept ? len_c : 7'd0);

        case (state_reg)
            S_RUN: begin
                if (flush_req) begin
                    state_next = (fill_next == 7'd0) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((pop && out_last) || (fill_reg == 7'd0)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                buf_next   = 96'd0;
                fill_next  = 7'd0;
                total_next = 24'd0;
                state_next = S_RUN;
            end
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_RUN;
            buf_reg   <= 96'd0;
            fill_reg  <= 7'd0;
            total_reg <= 24'd0;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            fill_reg  <= fill_next;
            total_reg <= total_next;
        end
    end

endmodule

// File: tb/tb_cavlc_bit_accumulator.sv
// Directed bench for cavlc_bit_accumulator: hand-computed words, flush and backpressure cases.
module tb_cavlc_bit_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_code;
    logic [6:0]  in_len;
    logic        flush_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [5:0]  out_nbits;
    logic        flush_done;
    logic [23:0] total_bits;

    int n_checks = 0;
    int n_fail   = 0;

    cavlc_bit_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_len     (in_len),
        .flush_req  (flush_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_nbits  (out_nbits),
        .flush_done (flush_done),
        .total_bits (total_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one chunk and hold it until accepted (bounded wait).
    task automatic send(input logic [63:0] code, input logic [6:0] len);
        int waited;
        in_valid = 1'b1;
        in_code  = code;
        in_len   = len;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        $display("send code=%h len=%0d", code, len);
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, out_last, flush_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/vld/last/done=%b required 1000",
                     {in_ready, out_valid, out_last, flush_done});
        end
        n_checks++;
        if (out_data !== 32'd0 || out_nbits !== 6'd0 || total_bits !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_values: data=%h nbits=%0d total=%0d required 0/0/0",
                     out_data, out_nbits, total_bits);
        end
        $display("reset done");
    endtask

    task automatic test_empty_flush();
        pulse_flush();
        n_checks++;
        if (flush_done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_flush: done=%b valid=%b required 1 0", flush_done, out_valid);
        end
        tick();
        n_checks++;
        if (flush_done !== 1'b0 || total_bits !== 24'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_flush_after: done=%b total=%0d rdy=%b required 0 0 1",
                     flush_done, total_bits, in_ready);
        end
        $display("empty flush done");
    endtask

    task automatic test_single_word();
        out_ready = 1'b0;
        send(64'hDEADBEEF_00000000, 7'd32);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_nbits !== 6'd32 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word: valid=%b data=%h nbits=%0d last=%b required 1 deadbeef 32 0",
                     out_valid, out_data, out_nbits, out_last);
        end
        n_checks++;
        if (total_bits !== 24'd32) begin
            n_fail++;
            $display("FAIL single_total: total=%0d required 32", total_bits);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: valid=%b required 0", out_valid);
        end
        $display("pop word=deadbeef");
    endtask

    task automatic test_split_flush();
        out_ready = 1'b0;
        send(64'hABC0_0000_0000_0000, 7'd12);
        send(64'h1230_0000_0000_0000, 7'd12);
        send(64'h4560_0000_0000_0000, 7'd12);
        n_checks++;
        if (total_bits !== 24'd36) begin
            n_fail++;
            $display("FAIL split_total: total=%0d required 36", total_bits);
        end
        pulse_flush();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hABC12345 || out_last !== 1'b0 || out_nbits !== 6'd32) begin
            n_fail++;
            $display("FAIL split_word0: valid=%b data=%h last=%b nbits=%0d required 1 abc12345 0 32",
                     out_valid, out_data, out_last, out_nbits);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h60000000 || out_last !== 1'b1 || out_nbits !== 6'd4) begin
            n_fail++;
            $display("FAIL split_word1: valid=%b data=%h last=%b nbits=%0d required 1 60000000 1 4",
                     out_valid, out_data, out_last, out_nbits);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (flush_done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL split_done: done=%b valid=%b required 1 0", flush_done, out_valid);
        end
        tick();
        n_checks++;
        if (total_bits !== 24'd0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL split_cleared: total=%0d done=%b required 0 0", total_bits, flush_done);
        end
        $display("split flush words=abc12345,60000000");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_len    = 7'd32;
        in_code   = 64'hA1A1A1A1_00000000;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_fill32: in_ready=%b required 1", in_ready);
        end
        in_code = 64'hB2B2B2B2_00000000;
        tick();
        in_code = 64'hC3C3C3C3_00000000;
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 32'hA1A1A1A1) begin
            n_fail++;
            $display("FAIL bp_ready_fill64: in_ready=%b data=%h required 0 a1a1a1a1", in_ready, out_data);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || total_bits !== 24'd64) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b total=%0d required 0 64", in_ready, total_bits);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hB2B2B2B2) begin
            n_fail++;
            $display("FAIL bp_pop1: valid=%b data=%h required 1 b2b2b2b2", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drained: valid=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        $display("backpressure words=a1a1a1a1,b2b2b2b2");
    endtask

    task automatic test_masking();
        out_ready = 1'b0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 7'd1);
        send(64'h0000_0000_0000_0000, 7'd31);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h80000000) begin
            n_fail++;
            $display("FAIL masking: valid=%b data=%h required 1 80000000", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("masking word=80000000");
    endtask

    task automatic test_exact_flush();
        out_ready = 1'b0;
        send(64'h01234567_89ABCDEF, 7'd100);
        n_checks++;
        if (total_bits !== 24'd64) begin
            n_fail++;
            $display("FAIL clamp_total: total=%0d required 64", total_bits);
        end
        pulse_flush();
        n_checks++;
        if (out_data !== 32'h01234567 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL exact_word0: data=%h last=%b required 01234567 0", out_data, out_last);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h89ABCDEF || out_last !== 1'b1 || out_nbits !== 6'd32) begin
            n_fail++;
            $display("FAIL exact_word1: valid=%b data=%h last=%b nbits=%0d required 1 89abcdef 1 32",
                     out_valid, out_data, out_last, out_nbits);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (flush_done !== 1'b1) begin
            n_fail++;
            $display("FAIL exact_done: done=%b required 1", flush_done);
        end
        tick();
        $display("exact flush words=01234567,89abcdef");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_len    = 7'd16;
        in_code   = 64'h1111_0000_0000_0000;
        tick();
        in_code = 64'h2222_0000_0000_0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h11112222 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_word0: valid=%b data=%h rdy=%b required 1 11112222 1",
                     out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        in_code   = 64'h3333_0000_0000_0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_fill16: valid=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        in_code   = 64'h4444_0000_0000_0000;
        flush_req = 1'b1;
        tick();
        in_valid  = 1'b0;
        flush_req = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h33334444 || out_last !== 1'b1 || out_nbits !== 6'd32) begin
            n_fail++;
            $display("FAIL b2b_last: valid=%b data=%h last=%b nbits=%0d required 1 33334444 1 32",
                     out_valid, out_data, out_last, out_nbits);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (flush_done !== 1'b1 || total_bits !== 24'd64) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b total=%0d required 1 64", flush_done, total_bits);
        end
        tick();
        $display("back-to-back words=11112222,33334444");
    endtask

    task automatic test_reset_mid_flush();
        out_ready = 1'b0;
        send(64'hFFFF_F000_0000_0000, 7'd20);
        pulse_flush();
        n_checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_nbits !== 6'd20 || out_data !== 32'hFFFFF000) begin
            n_fail++;
            $display("FAIL midflush_word: valid=%b last=%b nbits=%0d data=%h required 1 1 20 fffff000",
                     out_valid, out_last, out_nbits, out_data);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || flush_done !== 1'b0 || total_bits !== 24'd0) begin
            n_fail++;
            $display("FAIL midflush_reset: valid=%b rdy=%b done=%b total=%0d required 0 1 0 0",
                     out_valid, in_ready, flush_done, total_bits);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midflush_after: valid=%b done=%b required 0 0", out_valid, flush_done);
        end
        $display("reset mid-flush done");
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_code   = 64'd0;
        in_len    = 7'd0;
        flush_req = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_single_word();
        test_empty_flush();
        test_split_flush();
        test_backpressure();
        test_empty_flush();
        test_masking();
        test_empty_flush();
        test_exact_flush();
        test_back_to_back();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
